// File: rtl/l2_types.sv
// rtl/l2_types.sv - shared L2 / eviction write buffer types and constants
package l2_types;

    localparam int EWB_DEPTH_LG = 2;
    localparam int EWB_OFS_W    = 5;
    localparam int EWB_WIDTH    = 256;
    localparam int EWB_ADDR_W   = 32;
    localparam int EWB_TAG_W    = EWB_ADDR_W - EWB_OFS_W;

    // One buffer slot as seen by the L2 controller.
    typedef struct packed {
        logic                 valid;
        logic [EWB_TAG_W-1:0] tag;
        logic [EWB_WIDTH-1:0] data;
    } ewb_entry_t;

endpackage

// File: rtl/ewb_cam_match.sv
// rtl/ewb_cam_match.sv - one-hot tag CAM compare over all buffer entries
module ewb_cam_match #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 27
) (
    input  logic [DEPTH-1:0]       valid_i,
    input  logic [DEPTH*TAG_W-1:0] tags_i,
    input  logic [TAG_W-1:0]       key_i,
    output logic [DEPTH-1:0]       match_o
);

    // Compare the key against every valid tag in parallel.
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_i[i] && (tags_i[i*TAG_W +: TAG_W] == key_i);
        end
    end

endmodule

// File: rtl/ewb_coalesce.sv
// rtl/ewb_coalesce.sv - coalescing eviction write buffer between L2 and memory
module ewb_coalesce
    import l2_types::*;
#(
    parameter int WIDTH    = EWB_WIDTH,
    parameter int DEPTH_LG = EWB_DEPTH_LG,
    parameter int ADDR_W   = EWB_ADDR_W,
    parameter int OFS_W    = EWB_OFS_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq_valid_i,
    input  logic [ADDR_W-1:0]   enq_addr_i,
    input  logic [WIDTH-1:0]    enq_data_i,
    output logic                enq_ready_o,
    output logic                full_o,
    input  logic                lkp_valid_i,
    input  logic [ADDR_W-1:0]   lkp_addr_i,
    output logic                lkp_hit_o,
    output logic [WIDTH-1:0]    lkp_data_o,
    output logic                empty_o,
    output logic [ADDR_W-1:0]   drn_addr_o,
    output logic [WIDTH-1:0]    drn_data_o,
    input  logic                drn_yumi_i,
    output logic [DEPTH_LG:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LG;
    localparam int TAG_W = ADDR_W - OFS_W;
    localparam int CNT_W = DEPTH_LG + 1;
    localparam logic [DEPTH_LG-1:0] PTR_LAST  = DEPTH_LG'(DEPTH - 1);
    localparam logic [CNT_W-1:0]    CNT_DEPTH = CNT_W'(DEPTH);

    // Wrap by explicit compare so a non-power-of-two depth would still work.
    function automatic logic [DEPTH_LG-1:0] ptr_inc(input logic [DEPTH_LG-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [DEPTH_LG-1:0]         head_q;
    logic [DEPTH_LG-1:0]         tail_q;
    logic [CNT_W-1:0]            count_q;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [WIDTH-1:0]            data_q [DEPTH];

    logic [TAG_W-1:0]    enq_line;
    logic [TAG_W-1:0]    lkp_line;
    logic [DEPTH-1:0]    enq_match;
    logic [DEPTH-1:0]    lkp_match;
    logic [DEPTH_LG-1:0] coal_idx;
    logic                coalesce;
    logic                allocate;
    logic                alloc_fire;
    logic                drn_fire;
    logic                bypass;
    logic [WIDTH-1:0]    lkp_entry_data;
    logic                unused_ofs;

    assign enq_line   = enq_addr_i[ADDR_W-1:OFS_W];
    assign lkp_line   = lkp_addr_i[ADDR_W-1:OFS_W];
    assign unused_ofs = ^{enq_addr_i[OFS_W-1:0], lkp_addr_i[OFS_W-1:0]};

    ewb_cam_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_enq_cam (
        .valid_i (valid_q),
        .tags_i  (tag_q),
        .key_i   (enq_line),
        .match_o (enq_match)
    );

    ewb_cam_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lkp_cam (
        .valid_i (valid_q),
        .tags_i  (tag_q),
        .key_i   (lkp_line),
        .match_o (lkp_match)
    );

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_DEPTH);
    assign count_o = count_q;

    // Encode the (at most one-hot) enqueue match into an entry index.
    always_comb begin
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_match[i]) coal_idx = DEPTH_LG'(i);
        end
    end

    // A matching head that is draining this cycle cannot absorb new data;
    // the re-eviction then goes to the tail as a fresh entry.
    always_comb begin
        coalesce    = enq_valid_i && (|enq_match) && !(enq_match[head_q] && drn_yumi_i);
        allocate    = enq_valid_i && !coalesce;
        enq_ready_o = coalesce || (allocate && (!full_o || drn_yumi_i));
        alloc_fire  = allocate && enq_ready_o;
        drn_fire    = drn_yumi_i && !empty_o;
    end

    // Next valid bits: a full-buffer allocate lands on the draining head slot,
    // so the set must take priority over the clear.
    always_comb begin
        valid_d = valid_q;
        if (drn_fire)   valid_d[head_q] = 1'b0;
        if (alloc_fire) valid_d[tail_q] = 1'b1;
    end

    // Pointers, occupancy and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (alloc_fire) tail_q <= ptr_inc(tail_q);
            if (drn_fire)   head_q <= ptr_inc(head_q);
            if (alloc_fire && !drn_fire)      count_q <= count_q + 1'b1;
            else if (drn_fire && !alloc_fire) count_q <= count_q - 1'b1;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage; not reset, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tag_q[tail_q]  <= enq_line;
            data_q[tail_q] <= enq_data_i;
        end else if (coalesce) begin
            data_q[coal_idx] <= enq_data_i;
        end
    end

    // Drain port presents the head entry directly.
    always_comb begin
        drn_addr_o = {tag_q[head_q], {OFS_W{1'b0}}};
        drn_data_o = data_q[head_q];
    end

    // AND-OR select of the resident entry hit by the lookup.
    always_comb begin
        lkp_entry_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lkp_entry_data = lkp_entry_data | (data_q[i] & {WIDTH{lkp_match[i]}});
        end
    end

    // Lookup result: an accepted same-cycle enqueue of the line wins over storage.
    always_comb begin
        bypass     = enq_valid_i && enq_ready_o && (enq_line == lkp_line);
        lkp_hit_o  = lkp_valid_i && (bypass || (|lkp_match));
        lkp_data_o = '0;
        if (lkp_valid_i) begin
            if (bypass)          lkp_data_o = enq_data_i;
            else if (|lkp_match) lkp_data_o = lkp_entry_data;
        end
    end

    // Memory must not consume from an empty buffer.
    always @(posedge clk) begin
        if (!rst && drn_yumi_i) begin
            assert (!empty_o);
        end
    end

endmodule

// File: tb/tb_ewb_coalesce.sv
// tb/tb_ewb_coalesce.sv - directed scoreboard bench for ewb_coalesce
module tb_ewb_coalesce;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enq_valid_i = 1'b0;
    logic [31:0]  enq_addr_i = '0;
    logic [255:0] enq_data_i = '0;
    logic         enq_ready_o;
    logic         full_o;
    logic         lkp_valid_i = 1'b0;
    logic [31:0]  lkp_addr_i = '0;
    logic         lkp_hit_o;
    logic [255:0] lkp_data_o;
    logic         empty_o;
    logic [31:0]  drn_addr_o;
    logic [255:0] drn_data_o;
    logic         drn_yumi_i = 1'b0;
    logic [2:0]   count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0]  line;
        logic [255:0] data;
    } ent_t;

    ent_t exp_q[$];

    ewb_coalesce dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid_i (enq_valid_i),
        .enq_addr_i  (enq_addr_i),
        .enq_data_i  (enq_data_i),
        .enq_ready_o (enq_ready_o),
        .full_o      (full_o),
        .lkp_valid_i (lkp_valid_i),
        .lkp_addr_i  (lkp_addr_i),
        .lkp_hit_o   (lkp_hit_o),
        .lkp_data_o  (lkp_data_o),
        .empty_o     (empty_o),
        .drn_addr_o  (drn_addr_o),
        .drn_data_o  (drn_data_o),
        .drn_yumi_i  (drn_yumi_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [31:0] s);
        return {8{s}} ^ {s, 224'h0};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of enqueue/drain at posedge+1, check at the negedge
    // against the model, then advance the model and step past the next edge.
    task automatic drive(input bit ev, input logic [31:0] ea, input logic [255:0] ed, input bit y);
        int  idx;
        bit  coal;
        bit  rdy;
        enq_valid_i = ev;
        enq_addr_i  = ea;
        enq_data_i  = ed;
        drn_yumi_i  = y;
        #4;
        idx = -1;
        foreach (exp_q[i]) if (exp_q[i].line == ea[31:5]) idx = i;
        coal = ev && (idx >= 0) && !(idx == 0 && y);
        rdy  = coal || (ev && !coal && (exp_q.size() < 4 || y));
        check("enq_ready", 256'(enq_ready_o), 256'(rdy));
        if (y && exp_q.size() > 0) begin
            check("drn_addr", 256'(drn_addr_o), 256'({exp_q[0].line, 5'b0}));
            check("drn_data", drn_data_o, exp_q[0].data);
        end
        if (ev && rdy) begin
            if (coal) exp_q[idx].data = ed;
            else begin
                ent_t e;
                e.line = ea[31:5];
                e.data = ed;
                exp_q.push_back(e);
            end
        end
        if (y && exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        enq_valid_i = 1'b0;
        drn_yumi_i  = 1'b0;
        check("count", 256'(count_o), 256'(exp_q.size()));
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) drive(1'b0, '0, '0, 1'b1);
        check("empty_after_drain", 256'(empty_o), 256'(1));
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_empty", 256'(empty_o), 256'(1));
        check("rst_full", 256'(full_o), 256'(0));
        check("rst_count", 256'(count_o), 256'(0));
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 32'h1000;
        #1;
        check("rst_lkp_hit", 256'(lkp_hit_o), 256'(0));
        lkp_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: FIFO order and head advance.
        drive(1'b1, 32'h1000, mk(32'hA), 1'b0);
        drive(1'b1, 32'h2000, mk(32'hB), 1'b0);
        check("t1_count", 256'(count_o), 256'(2));
        check("t1_head_a", 256'(drn_addr_o), 256'(32'h1000));
        drive(1'b0, '0, '0, 1'b1);
        check("t1_head_b", 256'(drn_addr_o), 256'(32'h2000));
        drain_all();

        // 2: full buffer refuses, full with yumi accepts.
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i) << 8, mk(32'(i)), 1'b0);
        check("t2_full", 256'(full_o), 256'(1));
        drive(1'b1, 32'h0500, mk(32'h5), 1'b0);
        check("t2_full_hold", 256'(full_o), 256'(1));
        drive(1'b1, 32'h0500, mk(32'h55), 1'b1);
        check("t2_count4", 256'(count_o), 256'(4));
        drain_all();

        // 3: same-line re-eviction coalesces into the head.
        drive(1'b1, 32'h3000, mk(32'hD1), 1'b0);
        drive(1'b1, 32'h3010, mk(32'hD2), 1'b0);
        check("t3_count", 256'(count_o), 256'(1));
        check("t3_data", drn_data_o, mk(32'hD2));
        drain_all();

        // 4: matching head draining the same cycle allocates at the tail.
        drive(1'b1, 32'h4000, mk(32'h41), 1'b0);
        drive(1'b1, 32'h4000, mk(32'h42), 1'b1);
        check("t4_count", 256'(count_o), 256'(1));
        check("t4_tail", drn_data_o, mk(32'h42));
        drain_all();

        // 5: lookup bypass, miss, resident hit, and disabled lookup.
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 32'h5000;
        enq_valid_i = 1'b1;
        enq_addr_i  = 32'h5000;
        enq_data_i  = mk(32'hD3);
        #1;
        check("t5_byp_hit", 256'(lkp_hit_o), 256'(1));
        check("t5_byp_data", lkp_data_o, mk(32'hD3));
        lkp_addr_i = 32'h6000;
        #1;
        check("t5_miss_hit", 256'(lkp_hit_o), 256'(0));
        check("t5_miss_data", lkp_data_o, 256'(0));
        lkp_valid_i = 1'b0;
        drive(1'b1, 32'h5000, mk(32'hD3), 1'b0);
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 32'h5004;
        #1;
        check("t5_res_hit", 256'(lkp_hit_o), 256'(1));
        check("t5_res_data", lkp_data_o, mk(32'hD3));
        lkp_valid_i = 1'b0;
        #1;
        check("t5_lkp_off", 256'(lkp_hit_o), 256'(0));
        drain_all();

        // 6: asynchronous reset with entries resident and yumi high.
        drive(1'b1, 32'h7000, mk(32'h71), 1'b0);
        drive(1'b1, 32'h8000, mk(32'h81), 1'b0);
        drive(1'b1, 32'h9000, mk(32'h91), 1'b0);
        check("t6_count3", 256'(count_o), 256'(3));
        drn_yumi_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t6_empty", 256'(empty_o), 256'(1));
        check("t6_count0", 256'(count_o), 256'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        drn_yumi_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_post_count", 256'(count_o), 256'(0));
        lkp_valid_i = 1'b1;
        lkp_addr_i  = 32'h7000;
        #1;
        check("t6_post_lkp", 256'(lkp_hit_o), 256'(0));
        lkp_valid_i = 1'b0;
        drive(1'b1, 32'hA000, mk(32'hAA), 1'b0);
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
